shake_squeeze_stream: RTL and testbench
=======================================

# shake_squeeze_stream

Parametrised successor to the SHAKE256 single-shot truncation stage. It takes rate-wide squeeze blocks from the Keccak permutation and emits an arbitrary-length digest of up to MAX_L bits as a stream of WORD-bit words. When the requested length exceeds one rate block, it requests further permutations. It sits between the sponge core and the digest consumer (bus or output FIFO).

## Interface
- RATE, 1088, squeeze block width in bits; RATE % WORD == 0 required.
- WORD, 64, output word width in bits.
- MAX_L, 4096, maximum digest length in bits.
- LW, $clog2(MAX_L+1), width of the length fields.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a digest; sampled only in IDLE.
- out_len  in  LW  requested digest length in bits, sampled with start.
- blk_valid  in  1  squeeze block available.
- blk_ready  out  1  the block can be accepted.
- blk_data  in  RATE  squeeze block, LSB first; sampled on blk_valid && blk_ready.
- squeeze_req  out  1  one-cycle pulse requesting the next permutation.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WORD  output word; invalid upper bits are zero.
- out_bits  out  $clog2(WORD+1)  number of valid bits in out_data (1..WORD).
- out_last  out  1  marks the final word of the digest.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the digest is complete.

## Operation
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 latches rem = min(out_len, MAX_L).
  - If rem==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - blk_ready=1.
  - On handshake, copy blk_data into an internal RATE-bit buffer, set word index to 0, go to EMIT.
- EMIT:
  - out_valid=1.
  - out_data = buf[idx*WORD +: WORD] masked to min(rem, WORD) bits.
  - out_bits = min(rem, WORD); out_last = (rem <= WORD).
  - On out_valid && out_ready: rem -= out_bits and idx += 1.
    - If out_last, go to DONE.
    - Else if idx was RATE/WORD-1 (block exhausted), go to FETCH and pulse squeeze_req.
    - Else stay in EMIT.
- DONE: done=1 for one cycle, then IDLE.
- The first block is never requested: the sponge core supplies it after absorb. Only blocks after the first produce squeeze_req, so there are ceil(len/RATE)-1 pulses per digest.
- start outside IDLE is ignored. out_len > MAX_L is clamped to MAX_L.
- Output handshake: while out_valid && !out_ready, out_data, out_bits and out_last hold stable.
- Input handshake: blk_data only needs to be valid in the handshake cycle.
- Width rules:
  - rem and out_len are unsigned LW bits.
  - idx is $clog2(RATE/WORD) bits and never wraps past RATE/WORD-1.
- Reset (reset=0 at a clock edge, any state, including mid-EMIT):
  - State goes to IDLE; buffer, rem and idx clear.
  - All outputs are 0 after that edge.

## Timing
- start → FETCH (blk_ready=1) on the next cycle.
- Block handshake → out_valid on the next cycle, so first-word latency is 2 cycles from start when blk_valid is already high.
- Throughput: one word per cycle when out_ready=1.
- Block boundary: the cycle after the last word of a block is accepted, the state is FETCH and squeeze_req=1 (registered). The minimum gap between blocks is 1 cycle plus the permutation latency.
- done is high the cycle after the last word's handshake.
- For len=0, done is high 1 cycle after start.

## Structure
- A shared package shake_pkg holds the state enum and the default constants SHAKE256_RATE=1088 and SHAKE_WORD=64, reused by the sponge core and its testbenches.
- Single module, no sub-module. The word select/mask is a combinational function inside the block.

## Test plan
- Legacy equivalence: len=512, block lower 512 bits all ones. Expect 8 words of all ones, out_bits=64, out_last on word 8, done, no squeeze_req.
- Exact block: len=1088, random block. Expect 17 words equal to the block slices, out_last on word 17, no squeeze_req.
- Multi-block: len=1100. Expect 17 words from block 0, then one squeeze_req pulse; block 1 accepted. Then 1 word with out_bits=12, out_data[11:0]=block1[11:0], upper bits 0, out_last=1.
- Backpressure: len=200, out_ready toggling every cycle. Expect 4 words, stable while stalled, last word out_bits=8.
- Bounds: len=0 gives done 1 cycle after start with no out_valid. len=5000 is clamped: 64 words, 3 squeeze_req pulses, 4 blocks consumed.
- Control: reset=0 mid-EMIT clears all outputs next cycle, and a subsequent len=64 digest completes correctly. start asserted while busy is ignored, with no change to rem or the output sequence.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared SHAKE sponge definitions: default rate/word constants and the squeeze-stage state type.
package shake_pkg;

    localparam int SHAKE256_RATE = 1088;
    localparam int SHAKE_WORD    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } squeeze_state_e;

endpackage

// File: rtl/shake_squeeze_stream.sv
// Streams an arbitrary-length SHAKE digest as WORD-bit words, pulling further
// squeeze blocks from the sponge core whenever a rate block runs out.
module shake_squeeze_stream
    import shake_pkg::*;
#(
    parameter int RATE  = SHAKE256_RATE,
    parameter int WORD  = SHAKE_WORD,
    parameter int MAX_L = 4096,
    parameter int LW    = $clog2(MAX_L + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LW-1:0]              out_len,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    input  logic [RATE-1:0]            blk_data,
    output logic                       squeeze_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD-1:0]            out_data,
    output logic [$clog2(WORD+1)-1:0]  out_bits,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int NW = RATE / WORD;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int BW = $clog2(WORD + 1);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_L);
    localparam logic [LW-1:0] WORD_LEN = LW'(WORD);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    squeeze_state_e  state_q, state_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RATE-1:0] buf_q, buf_d;
    logic            sqz_q, sqz_d;

    logic [LW-1:0]   lenClamped;
    logic [BW-1:0]   wordBits;
    logic            lastWord;

    // Pick word idx out of the buffered block and zero everything above nbits.
    function automatic logic [WORD-1:0] select_word(input logic [RATE-1:0] blk,
                                                    input logic [IW-1:0]   idx,
                                                    input logic [BW-1:0]   nbits);
        logic [WORD-1:0] w;
        logic [WORD-1:0] mask;
        w = blk[int'(idx)*WORD +: WORD];
        for (int i = 0; i < WORD; i++) begin
            mask[i] = (i < int'(nbits));
        end
        return w & mask;
    endfunction

    assign lenClamped = (out_len > MAX_LEN) ? MAX_LEN : out_len;
    assign lastWord   = (rem_q <= WORD_LEN);
    assign wordBits   = lastWord ? BW'(rem_q) : BW'(WORD);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        sqz_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = lenClamped;
                    state_d = (lenClamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (blk_valid) begin
                    buf_d   = blk_data;
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    rem_d = rem_q - LW'(wordBits);
                    if (lastWord) begin
                        state_d = ST_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        // Block exhausted: idx stays put, FETCH reloads it to zero.
                        state_d = ST_FETCH;
                        sqz_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            sqz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            sqz_q   <= sqz_d;
        end
    end

    assign blk_ready   = (state_q == ST_FETCH);
    assign out_valid   = (state_q == ST_EMIT);
    assign out_data    = out_valid ? select_word(buf_q, idx_q, wordBits) : '0;
    assign out_bits    = out_valid ? wordBits : '0;
    assign out_last    = out_valid && lastWord;
    assign squeeze_req = sqz_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_shake_squeeze_stream.sv
// Self-checking bench for shake_squeeze_stream: random blocks and lengths checked
// against a bit-offset model of the digest stream.
module tb_shake_squeeze_stream;

    localparam int RATE  = 1088;
    localparam int WORD  = 64;
    localparam int MAX_L = 4096;
    localparam int LW    = 13;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LW-1:0]    out_len;
    logic             blk_valid;
    logic             blk_ready;
    logic [RATE-1:0]  blk_data;
    logic             squeeze_req;
    logic             out_valid;
    logic             out_ready;
    logic [WORD-1:0]  out_data;
    logic [6:0]       out_bits;
    logic             out_last;
    logic             busy;
    logic             done;

    shake_squeeze_stream dut (
        .clk(clk), .reset(reset), .start(start), .out_len(out_len),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .squeeze_req(squeeze_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RATE-1:0] blocks [4];
    int errors = 0;
    int checks = 0;

    logic [WORD-1:0] capData [$];
    int              capBits [$];
    bit              capLast [$];
    int sqzCount, accCount, doneCount, cycle, lastHsCycle, doneCycle;
    int stallViol, sqzOutsideFetch, validSeen, readyMode, permCnt;
    logic [WORD-1:0] heldData;
    logic [6:0]      heldBits;
    logic            heldLast;
    bit              prevStall;

    // Sponge-core and consumer stand-in: drives inputs and records traffic on the falling edge.
    always @(negedge clk) begin
        cycle++;
        if (squeeze_req) begin
            sqzCount++;
            if (!blk_ready) sqzOutsideFetch++;
            permCnt = 3;
        end else if (permCnt > 0) begin
            permCnt--;
        end
        blk_valid = (permCnt == 0);
        blk_data  = blocks[(accCount > 3) ? 3 : accCount];
        if (blk_valid && blk_ready) accCount++;
        out_ready = (readyMode == 1) ? ~out_ready : 1'b1;
        if (prevStall && out_valid) begin
            if (out_data !== heldData || out_bits !== heldBits || out_last !== heldLast) stallViol++;
        end
        if (out_valid) validSeen++;
        if (out_valid && out_ready) begin
            capData.push_back(out_data);
            capBits.push_back(int'(out_bits));
            capLast.push_back(out_last);
            lastHsCycle = cycle;
        end
        prevStall = out_valid && !out_ready;
        heldData  = out_data;
        heldBits  = out_bits;
        heldLast  = out_last;
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
    end

    function automatic int clamp_len(int len);
        return (len > MAX_L) ? MAX_L : len;
    endfunction

    function automatic int exp_words(int len);
        return (clamp_len(len) + WORD - 1) / WORD;
    endfunction

    function automatic int exp_bits(int len, int k);
        int left;
        left = clamp_len(len) - k * WORD;
        return (left >= WORD) ? WORD : left;
    endfunction

    // Digest bit n is bit n%RATE of block n/RATE; bits beyond the length read as zero.
    function automatic logic [WORD-1:0] exp_data(int len, int k);
        logic [WORD-1:0] r;
        int off;
        r   = '0;
        off = k * WORD;
        for (int j = 0; j < exp_bits(len, k); j++) begin
            r[j] = blocks[(off + j) / RATE][(off + j) % RATE];
        end
        return r;
    endfunction

    function automatic int exp_sqz(int len);
        int nb;
        nb = (clamp_len(len) + RATE - 1) / RATE;
        return (nb == 0) ? 0 : nb - 1;
    endfunction

    task automatic fill_blocks();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < RATE / 32; w++) begin
                blocks[b][w*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic clear_capture();
        capData.delete();
        capBits.delete();
        capLast.delete();
        sqzCount = 0; accCount = 0; doneCount = 0; stallViol = 0;
        sqzOutsideFetch = 0; validSeen = 0; prevStall = 0;
        lastHsCycle = -1; doneCycle = -1;
    endtask

    task automatic start_digest(input int len);
        @(negedge clk);
        start   = 1'b1;
        out_len = LW'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int maxCycles);
        for (int i = 0; i < maxCycles && doneCount == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_words(input int n, input int maxCycles);
        for (int i = 0; i < maxCycles && capData.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, blk_ready, squeeze_req, out_last, busy, done, out_bits, out_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b ready=%b sqz=%b last=%b busy=%b done=%b bits=%0d data=%h, required all zero",
                     out_valid, blk_ready, squeeze_req, out_last, busy, done, out_bits, out_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_legacy();
        int len = 512;
        int n;
        fill_blocks();
        blocks[0][511:0] = '1;
        clear_capture();
        @(negedge clk);
        start = 1'b1; out_len = LW'(len);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL legacy_fetch_latency: got blk_ready=%b busy=%b, required 1 1", blk_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL legacy_first_word_latency: got out_valid=%b, required 1", out_valid);
        end
        wait_done(200);
        n = exp_words(len);
        checks++;
        if (capData.size() !== n || doneCount !== 1 || sqzCount !== 0) begin
            errors++;
            $display("[TB] FAIL legacy_counts: got words=%0d done=%0d sqz=%0d, required %0d 1 0",
                     capData.size(), doneCount, sqzCount, n);
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== 64'hFFFF_FFFF_FFFF_FFFF || capBits[k] !== 64 || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL legacy_word%0d: got data=%h bits=%0d last=%b, required all ones 64 %b",
                         k, capData[k], capBits[k], capLast[k], k == n - 1);
            end
        end
    endtask

    task automatic test_exact_block();
        int len = 1088;
        int n;
        fill_blocks();
        clear_capture();
        start_digest(len);
        wait_done(300);
        n = exp_words(len);
        checks++;
        if (capData.size() !== n || doneCount !== 1 || sqzCount !== 0 || accCount !== 1) begin
            errors++;
            $display("[TB] FAIL exact_counts: got words=%0d done=%0d sqz=%0d blocks=%0d, required %0d 1 0 1",
                     capData.size(), doneCount, sqzCount, accCount, n);
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL exact_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                         k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
            end
        end
    endtask

    task automatic test_multi_block();
        int len = 1100;
        int n;
        logic [WORD-1:0] tailWord;
        fill_blocks();
        clear_capture();
        start_digest(len);
        wait_done(300);
        n = exp_words(len);
        checks++;
        if (capData.size() !== n || sqzCount !== 1 || accCount !== 2 || sqzOutsideFetch !== 0) begin
            errors++;
            $display("[TB] FAIL multi_counts: got words=%0d sqz=%0d blocks=%0d sqzOutsideFetch=%0d, required %0d 1 2 0",
                     capData.size(), sqzCount, accCount, sqzOutsideFetch, n);
        end
        tailWord = '0;
        tailWord[11:0] = blocks[1][11:0];
        if (capData.size() == n) begin
            checks++;
            if (capData[17] !== tailWord || capBits[17] !== 12 || capLast[17] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL multi_tail: got data=%h bits=%0d last=%b, required %h 12 1",
                         capData[17], capBits[17], capLast[17], tailWord);
            end
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL multi_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                         k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
            end
        end
        checks++;
        if (doneCycle !== lastHsCycle + 1) begin
            errors++;
            $display("[TB] FAIL multi_done_timing: got done cycle %0d, required %0d", doneCycle, lastHsCycle + 1);
        end
    endtask

    task automatic test_backpressure();
        int len = 200;
        int n;
        fill_blocks();
        clear_capture();
        readyMode = 1;
        start_digest(len);
        wait_done(300);
        readyMode = 0;
        n = exp_words(len);
        checks++;
        if (capData.size() !== n || stallViol !== 0 || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL backpressure_counts: got words=%0d stallViolations=%0d done=%0d, required %0d 0 1",
                     capData.size(), stallViol, doneCount, n);
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL backpressure_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                         k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
            end
        end
    endtask

    task automatic test_bounds();
        int len;
        int n;
        clear_capture();
        start_digest(0);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_len_done: got done=%b out_valid=%b, required 1 0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || validSeen !== 0) begin
            errors++;
            $display("[TB] FAIL zero_len_after: got done=%b busy=%b validCycles=%0d, required 0 0 0", done, busy, validSeen);
        end

        len = 5000;
        fill_blocks();
        clear_capture();
        start_digest(len);
        wait_done(600);
        n = exp_words(len);
        checks++;
        if (capData.size() !== 64 || n !== 64 || sqzCount !== 3 || accCount !== 4 || doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL clamp_counts: got words=%0d sqz=%0d blocks=%0d done=%0d, required 64 3 4 1",
                     capData.size(), sqzCount, accCount, doneCount);
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL clamp_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                         k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
            end
        end
    endtask

    task automatic test_control();
        int len;
        int n;
        fill_blocks();
        clear_capture();
        start_digest(1100);
        wait_words(5, 200);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({out_valid, blk_ready, squeeze_req, out_last, busy, done, out_bits, out_data} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got valid=%b ready=%b sqz=%b last=%b busy=%b done=%b bits=%0d data=%h, required all zero",
                     out_valid, blk_ready, squeeze_req, out_last, busy, done, out_bits, out_data);
        end
        repeat (4) @(negedge clk);
        clear_capture();
        start_digest(64);
        wait_done(200);
        checks++;
        if (capData.size() !== 1 || doneCount !== 1 || sqzCount !== 0) begin
            errors++;
            $display("[TB] FAIL postreset_counts: got words=%0d done=%0d sqz=%0d, required 1 1 0",
                     capData.size(), doneCount, sqzCount);
        end else begin
            checks++;
            if (capData[0] !== blocks[0][63:0] || capBits[0] !== 64 || capLast[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL postreset_word: got data=%h bits=%0d last=%b, required %h 64 1",
                         capData[0], capBits[0], capLast[0], blocks[0][63:0]);
            end
        end

        len = 300;
        fill_blocks();
        clear_capture();
        start_digest(len);
        wait_words(2, 100);
        @(negedge clk);
        start = 1'b1; out_len = LW'(64);
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        n = exp_words(len);
        checks++;
        if (capData.size() !== n || doneCount !== 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_counts: got words=%0d done=%0d busy=%b, required %0d 1 0",
                     capData.size(), doneCount, busy, n);
        end
        for (int k = 0; k < capData.size() && k < n; k++) begin
            checks++;
            if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                errors++;
                $display("[TB] FAIL busy_start_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                         k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
            end
        end
    endtask

    task automatic test_random();
        int len;
        int n;
        for (int t = 0; t < 3; t++) begin
            len = $urandom_range(1, MAX_L);
            fill_blocks();
            clear_capture();
            readyMode = $urandom_range(0, 1);
            start_digest(len);
            wait_done(1200);
            readyMode = 0;
            n = exp_words(len);
            checks++;
            if (capData.size() !== n || sqzCount !== exp_sqz(len) || doneCount !== 1 ||
                stallViol !== 0 || doneCycle !== lastHsCycle + 1) begin
                errors++;
                $display("[TB] FAIL random%0d_len%0d_counts: got words=%0d sqz=%0d done=%0d stall=%0d doneCycle=%0d, required %0d %0d 1 0 %0d",
                         t, len, capData.size(), sqzCount, doneCount, stallViol, doneCycle, n, exp_sqz(len), lastHsCycle + 1);
            end
            for (int k = 0; k < capData.size() && k < n; k++) begin
                checks++;
                if (capData[k] !== exp_data(len, k) || capBits[k] !== exp_bits(len, k) || capLast[k] !== (k == n - 1)) begin
                    errors++;
                    $display("[TB] FAIL random%0d_word%0d: got data=%h bits=%0d last=%b, required %h %0d %b",
                             t, k, capData[k], capBits[k], capLast[k], exp_data(len, k), exp_bits(len, k), k == n - 1);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        out_len   = '0;
        blk_valid = 1'b0;
        blk_data  = '0;
        out_ready = 1'b0;
        readyMode = 0;
        permCnt   = 0;
        cycle     = 0;
        fill_blocks();
        clear_capture();
        test_reset();
        test_legacy();
        test_exact_block();
        test_multi_block();
        test_backpressure();
        test_bounds();
        test_control();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
